// File: rtl/sap_control_sequencer_if.sv
// sap_control_sequencer_if: run control, instruction/flag inputs and control-word outputs of the SAP sequencer.
interface sap_control_sequencer_if;
    logic        enable;
    logic [3:0]  opcode;
    logic        carry_flag;
    logic        zero_flag;
    logic [15:0] ctrl;
    logic [2:0]  step;
    logic        halted;
    modport master (output enable, opcode, carry_flag, zero_flag, input ctrl, step, halted);
    modport slave  (input enable, opcode, carry_flag, zero_flag, output ctrl, step, halted);
endinterface

// File: rtl/sap_control_sequencer.sv
// sap_control_sequencer: SAP-1 microstep counter and control-word decoder.
// Define SEQ_EARLY_END_EN to return to T0 right after each opcode's last active microstep.
module sap_control_sequencer #(
    parameter int STEPS = 5
) (
    input logic clk,
    input logic reset,
    sap_control_sequencer_if.slave bus
);
    logic [2:0]  step, step_nxt, last;
    logic        halted, halted_nxt;
    logic [15:0] word;
`ifdef SEQ_EARLY_END_EN
    assign last = (bus.opcode == 4'd1 || bus.opcode == 4'd4) ? 3'd3 :
                  (bus.opcode == 4'd2 || bus.opcode == 4'd3) ? 3'd4 : 3'd2;
`else
    assign last = 3'(STEPS - 1);
`endif
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step   <= 3'd0;
            halted <= 1'b0;
        end else begin
            step   <= step_nxt;
            halted <= halted_nxt;
        end
    end
    // HLT latches at T2 instead of advancing, so the counter freezes there.
    always_comb begin
        step_nxt   = step;
        halted_nxt = halted;
        if (bus.enable && !halted) begin
            if (step == 3'd2 && bus.opcode == 4'd15) halted_nxt = 1'b1;
            else step_nxt = (step == last) ? 3'd0 : step + 3'd1;
        end
    end
    always_comb begin
        word = 16'h0000;
        case (step)
            3'd0: word = 16'h4004;
            3'd1: word = 16'h1408;
            3'd2: case (bus.opcode)
                4'd1, 4'd2, 4'd3, 4'd4: word = 16'h4800;
                4'd5:  word = 16'h0A00;
                4'd6:  word = 16'h0802;
                4'd7:  word = bus.carry_flag ? 16'h0802 : 16'h0000;
                4'd8:  word = bus.zero_flag ? 16'h0802 : 16'h0000;
                4'd9:  word = 16'h0001;
                4'd14: word = 16'h0110;
                4'd15: word = 16'h8000;
                default: word = 16'h0000;
            endcase
            3'd3: case (bus.opcode)
                4'd1:       word = 16'h1200;
                4'd2, 4'd3: word = 16'h1020;
                4'd4:       word = 16'h2100;
                default:    word = 16'h0000;
            endcase
            3'd4: word = (bus.opcode == 4'd2) ? 16'h0280 : (bus.opcode == 4'd3) ? 16'h02C0 : 16'h0000;
            default: word = 16'h0000;
        endcase
    end
    assign bus.ctrl   = !reset ? 16'h0000 : halted ? 16'h8000 : bus.enable ? word : 16'h0000;
    assign bus.step   = step;
    assign bus.halted = halted;
endmodule

// File: tb/tb_sap_control_sequencer.sv
// tb_sap_control_sequencer: scoreboard bench with a microprogram-table reference model.
module tb_sap_control_sequencer;
    localparam int STEPS = 5;
    logic clk = 1'b0;
    logic reset = 1'b0;
    sap_control_sequencer_if bus();
    sap_control_sequencer #(.STEPS(STEPS)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    always #5 clk = ~clk;

    typedef struct packed {logic [15:0] c; logic [2:0] s; logic h;} obs_t;
    obs_t exp_q[$];
    int total = 0;
    int bad = 0;
    logic [15:0] prog [16][STEPS];
    int pos = 0;
    bit hlt = 1'b0;
    bit early = 1'b0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", n, a, e, $time);
        end
    endtask

    function automatic int ilen(input logic [3:0] op);
        int l = 2;
        if (!early) return STEPS;
        for (int k = 3; k < STEPS; k++) if (prog[op][k] != 16'h0) l = k;
        return l + 1;
    endfunction

    function automatic logic [15:0] model_ctrl();
        logic [15:0] w;
        if (!reset) return 16'h0;
        if (hlt) return 16'h8000;
        if (!bus.enable) return 16'h0;
        w = prog[bus.opcode][pos];
        if (pos == 2 && bus.opcode == 4'd7 && !bus.carry_flag) w = 16'h0;
        if (pos == 2 && bus.opcode == 4'd8 && !bus.zero_flag) w = 16'h0;
        return w;
    endfunction

    task automatic cycle(input bit r, input bit en, input logic [3:0] op, input bit c, input bit z);
        @(posedge clk);
        if (reset && bus.enable && !hlt) begin
            if (bus.opcode == 4'd15 && pos == 2) hlt = 1'b1;
            else pos = (pos + 1 == ilen(bus.opcode)) ? 0 : pos + 1;
        end
        #2;
        reset = r; bus.enable = en; bus.opcode = op; bus.carry_flag = c; bus.zero_flag = z;
        #1;
        if (!reset) begin pos = 0; hlt = 1'b0; end
        exp_q.push_back({model_ctrl(), 3'(pos), hlt});
    endtask

    always @(negedge clk) begin
        obs_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ctrl", {16'h0, bus.ctrl}, {16'h0, e.c});
            chk("step", {29'h0, bus.step}, {29'h0, e.s});
            chk("halted", {31'h0, bus.halted}, {31'h0, e.h});
        end
    end

    logic [15:0] lda_v [6];
    logic [2:0]  ldi_s [6];
    logic [3:0]  cur_op;

    initial begin
`ifdef SEQ_EARLY_END_EN
        early = 1'b1;
        lda_v = '{16'h4004, 16'h1408, 16'h4800, 16'h1200, 16'h4004, 16'h1408};
        ldi_s = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2};
`else
        lda_v = '{16'h4004, 16'h1408, 16'h4800, 16'h1200, 16'h0000, 16'h4004};
        ldi_s = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
`endif
        for (int o = 0; o < 16; o++) for (int k = 0; k < STEPS; k++) prog[o][k] = 16'h0;
        for (int o = 0; o < 16; o++) begin prog[o][0] = 16'h4004; prog[o][1] = 16'h1408; end
        prog[1][2] = 16'h4800; prog[1][3] = 16'h1200;
        prog[2][2] = 16'h4800; prog[2][3] = 16'h1020; prog[2][4] = 16'h0280;
        prog[3][2] = 16'h4800; prog[3][3] = 16'h1020; prog[3][4] = 16'h02C0;
        prog[4][2] = 16'h4800; prog[4][3] = 16'h2100;
        prog[5][2] = 16'h0A00; prog[6][2] = 16'h0802; prog[7][2] = 16'h0802; prog[8][2] = 16'h0802;
        prog[9][2] = 16'h0001; prog[14][2] = 16'h0110; prog[15][2] = 16'h8000;
        bus.enable = 1'b1; bus.opcode = 4'd0; bus.carry_flag = 1'b0; bus.zero_flag = 1'b0;
        #1 chk("reset_ctrl", {16'h0, bus.ctrl}, 32'h0);
        cycle(0, 1, 1, 0, 0);
        for (int i = 0; i < 6; i++) begin
            cycle(1, 1, 1, 0, 0);
            chk($sformatf("lda_t%0d", i), {16'h0, bus.ctrl}, {16'h0, lda_v[i]});
        end
        for (int cf = 0; cf < 2; cf++) begin
            cycle(0, 1, 7, 0, 0);
            for (int i = 0; i < 3; i++) cycle(1, 1, 7, cf[0], 0);
            chk($sformatf("jc_c%0d", cf), {16'h0, bus.ctrl}, cf ? 32'h0802 : 32'h0);
        end
        cycle(0, 1, 3, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1, 1, 3, 0, 0);
        chk("sub_t3", {16'h0, bus.ctrl}, 32'h1020);
        cycle(1, 1, 3, 0, 0);
        chk("sub_t4", {16'h0, bus.ctrl}, 32'h02C0);
        cycle(0, 1, 15, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 1, 15, 0, 0);
        chk("hlt_t2", {16'h0, bus.ctrl}, 32'h8000);
        for (int i = 0; i < 20; i++) cycle(1, 1, 15, 0, 0);
        chk("hlt_halted", {31'h0, bus.halted}, 32'h1);
        chk("hlt_step", {29'h0, bus.step}, 32'h2);
        cycle(0, 1, 15, 0, 0);
        chk("async_step", {29'h0, bus.step}, 32'h0);
        chk("async_halted", {31'h0, bus.halted}, 32'h0);
        chk("async_ctrl", {16'h0, bus.ctrl}, 32'h0);
        for (int i = 0; i < 3; i++) cycle(1, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 1, 0, 0);
            chk("hold_ctrl", {16'h0, bus.ctrl}, 32'h0);
            chk("hold_step", {29'h0, bus.step}, 32'h3);
        end
        cycle(1, 1, 1, 0, 0);
        cycle(1, 1, 1, 0, 0);
        chk("resume_step", {29'h0, bus.step}, early ? 32'h0 : 32'h4);
        cycle(0, 1, 5, 0, 0);
        for (int i = 0; i < 6; i++) begin
            cycle(1, 1, 5, 0, 0);
            chk($sformatf("ldi_s%0d", i), {29'h0, bus.step}, {29'h0, ldi_s[i]});
        end
        cur_op = 4'd0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) cur_op = 4'($urandom_range(0, 15));
            cycle($urandom_range(0, 99) > 2, $urandom_range(0, 99) < 85, cur_op,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        @(negedge clk);
        @(negedge clk);
        chk("drain", exp_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
